// File: rtl/cmp_sort_ctrl_pkg.sv
// cmp_sort_ctrl_pkg: shared FSM state type and sizing constants for the 4-element sorter
package cmp_sort_ctrl_pkg;
   localparam int ELEM_W    = 4;
   localparam int NUM_ELEM  = 4;
   localparam int MAX_SWAPS = 6;
   localparam int SWAP_W    = $clog2(MAX_SWAPS + 1);
   typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;
endpackage

// File: rtl/cmp_sort_ctrl_mag_cmp4.sv
// mag_cmp4: 4-bit unsigned magnitude comparator shared by every sort step
module mag_cmp4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic       gt,
   output logic       eq,
   output logic       lt
);
   assign gt = a > b;
   assign eq = a == b;
   assign lt = a < b;
endmodule

// File: rtl/cmp_sort_ctrl.sv
// cmp_sort_ctrl: bubble sort of four 4-bit elements, one comparison per cycle,
// early exit on a pass without swaps
module cmp_sort_ctrl
   import cmp_sort_ctrl_pkg::*;
#(
   parameter logic DESCEND = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [ELEM_W*NUM_ELEM-1:0] data_in,
   output logic                       busy,
   output logic                       done,
   output logic [ELEM_W*NUM_ELEM-1:0] sorted_out,
   output logic [SWAP_W-1:0]          swap_count
);
   state_t                       state_q, state_d;
   logic [ELEM_W-1:0]            w_q [NUM_ELEM];
   logic [ELEM_W-1:0]            w_d [NUM_ELEM];
   logic [1:0]                   pass_q, pass_d;
   logic [1:0]                   idx_q, idx_d;
   logic [SWAP_W-1:0]            swaps_q, swaps_d;
   logic [1:0]                   pswaps_q, pswaps_d;
   logic [ELEM_W*NUM_ELEM-1:0]   sorted_q, sorted_d;
   logic [SWAP_W-1:0]            count_q, count_d;
   logic [1:0]                   idx_n;
   logic [ELEM_W-1:0]            cmp_a, cmp_b;
   logic                         gt, eq, lt, swap, last;

   assign idx_n = idx_q + 2'd1;
   assign cmp_a = w_q[idx_q];
   assign cmp_b = w_q[idx_n];

   mag_cmp4 u_cmp (
      .a  (cmp_a),
      .b  (cmp_b),
      .gt (gt),
      .eq (eq),
      .lt (lt)
   );

   // eq never swaps, which keeps equal elements in their original order
   assign swap = DESCEND ? (lt && !eq) : (gt && !eq);
   assign last = idx_q == (2'd2 - pass_q);

   always_comb begin
      state_d  = state_q;
      w_d      = w_q;
      pass_d   = pass_q;
      idx_d    = idx_q;
      swaps_d  = swaps_q;
      pswaps_d = pswaps_q;
      sorted_d = sorted_q;
      count_d  = count_q;
      case (state_q)
         IDLE: if (start) begin
            for (int i = 0; i < NUM_ELEM; i++) w_d[i] = data_in[i*ELEM_W +: ELEM_W];
            pass_d   = '0;
            idx_d    = '0;
            swaps_d  = '0;
            pswaps_d = '0;
            state_d  = SORT;
         end
         SORT: begin
            if (swap) begin
               w_d[idx_q] = cmp_b;
               w_d[idx_n] = cmp_a;
               swaps_d    = swaps_q + 1'b1;
               pswaps_d   = pswaps_q + 2'd1;
            end
            if (!last) idx_d = idx_n;
            else if ((pswaps_q == 2'd0 && !swap) || pass_q == 2'd2) begin
               state_d  = DONE;
               sorted_d = {w_d[3], w_d[2], w_d[1], w_d[0]};
               count_d  = swaps_d;
            end else begin
               pass_d   = pass_q + 2'd1;
               idx_d    = '0;
               pswaps_d = '0;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         w_q      <= '{default: '0};
         pass_q   <= '0;
         idx_q    <= '0;
         swaps_q  <= '0;
         pswaps_q <= '0;
         sorted_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         w_q      <= w_d;
         pass_q   <= pass_d;
         idx_q    <= idx_d;
         swaps_q  <= swaps_d;
         pswaps_q <= pswaps_d;
         sorted_q <= sorted_d;
         count_q  <= count_d;
      end
   end

   assign busy       = state_q != IDLE;
   assign done       = state_q == DONE;
   assign sorted_out = sorted_q;
   assign swap_count = count_q;
endmodule
